// File: rtl/dadda_product_accumulator_if.sv
// Product/result bus for dadda_product_accumulator.
//   master : upstream producer + downstream consumer side
//            (drives in_valid, product, out_ready)
//   slave  : accumulator side
//            (drives in_ready, out_valid, out_data, out_ovf)
// Parameters BIT and ACC_W must match those of the attached accumulator.
interface dadda_product_accumulator_if #(
  parameter int BIT   = 8,
  parameter int ACC_W = 20
);
  logic               in_valid;
  logic               in_ready;
  logic [2*BIT-1:0]   product;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic               out_ovf;

  modport master (
    output in_valid, product, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, product, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/dadda_product_accumulator.sv
// Registered accumulation stage behind the DADDA_8x8 multiplier. Sums VEC_LEN
// consecutive 2*BIT-bit unsigned products into an ACC_W-bit result, which is
// offered on a valid/ready port together with a per-vector overflow flag.
//
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   clear    : synchronous abort of the current vector (drops pending result)
//   bus      : slave side of dadda_product_accumulator_if
//              in_valid/in_ready/product  - product input handshake
//              out_valid/out_ready        - result handshake
//              out_data/out_ovf           - result and overflow flag
//
// Configuration macro: DADDA_ACC_SAT_EN
//   defined   : accumulation saturates at all-ones on carry out
//   undefined : accumulation wraps modulo 2^ACC_W; out_ovf reports the wrap
module dadda_product_accumulator #(
  parameter int BIT     = 8,
  parameter int ACC_W   = 20,
  parameter int VEC_LEN = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        clear,
  dadda_product_accumulator_if.slave  bus
);

  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;

  logic [SUM_W-1:0]   sum;
  logic               carry;
  logic [ACC_W-1:0]   acc_upd;

  // One extra bit on the adder exposes the carry out of bit ACC_W-1.
  always_comb begin
    sum   = {1'b0, acc_q} + SUM_W'(bus.product);
    carry = sum[ACC_W];
`ifdef DADDA_ACC_SAT_EN
    // Once clamped, any further non-zero product carries again, so the
    // accumulator stays at all-ones for the remainder of the vector.
    acc_upd = carry ? '1 : sum[ACC_W-1:0];
`else
    acc_upd = sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      // out_data intentionally keeps its last value.
      acc_d       = '0;
      cnt_d       = '0;
      ovf_acc_d   = 1'b0;
      out_valid_d = 1'b0;
      out_ovf_d   = 1'b0;
      state_d     = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (bus.in_valid) begin
            if (cnt_q == CNT_LAST) begin
              out_data_d  = acc_upd;
              out_ovf_d   = ovf_acc_q | carry;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_acc_d   = 1'b0;
              state_d     = ST_HOLD;
            end else begin
              acc_d     = acc_upd;
              cnt_d     = cnt_q + 1'b1;
              ovf_acc_d = ovf_acc_q | carry;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Self-checking bench for dadda_product_accumulator. Instance A uses the
// default ACC_W=20, instance B uses ACC_W=16 to exercise overflow.
module tb_dadda_product_accumulator;

  localparam int BIT = 8;
  localparam int VEC = 4;
  localparam int WA  = 20;
  localparam int WB  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_a;
  logic clr_b;

  always #5 clk = ~clk;

  dadda_product_accumulator_if #(.BIT(BIT), .ACC_W(WA)) bus_a ();
  dadda_product_accumulator_if #(.BIT(BIT), .ACC_W(WB)) bus_b ();

  dadda_product_accumulator #(.BIT(BIT), .ACC_W(WA), .VEC_LEN(VEC)) u_dut_a (
    .clock   (clk),
    .reset_n (rst_n),
    .clear   (clr_a),
    .bus     (bus_a)
  );

  dadda_product_accumulator #(.BIT(BIT), .ACC_W(WB), .VEC_LEN(VEC)) u_dut_b (
    .clock   (clk),
    .reset_n (rst_n),
    .clear   (clr_b),
    .bus     (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference for instance A: a queue of accepted products
  // and a flag saying whether a finished result is waiting for the consumer.
  bit     m_hold;
  bit     m_ovf;
  longint m_data;
  longint m_prods[$];

  function automatic longint exp_sum(longint total, int w);
    longint lim;
    lim = longint'(1) << w;
`ifdef DADDA_ACC_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  function automatic void model_reset();
    m_hold = 1'b0;
    m_ovf  = 1'b0;
    m_data = 0;
    m_prods.delete();
  endfunction

  function automatic void model_edge();
    longint total;
    if (clr_a) begin
      m_prods.delete();
      m_hold = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_hold) begin
      if (bus_a.out_ready) m_hold = 1'b0;
    end else if (bus_a.in_valid) begin
      m_prods.push_back(longint'(bus_a.product));
      if (m_prods.size() == VEC) begin
        total = 0;
        foreach (m_prods[i]) total += m_prods[i];
        m_data = exp_sum(total, WA);
        m_ovf  = (total >= (longint'(1) << WA));
        m_hold = 1'b1;
        m_prods.delete();
      end
    end
  endfunction

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_prod();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = 8'($urandom);
    return 16'(a * b);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data} !== {1'b0, 1'b1, 1'b0, 20'd0}) begin
      n_bad++;
      $display("FAIL reset_a: got v=%b r=%b o=%b d=%0d want v=0 r=1 o=0 d=0",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data);
    end
    n_cmp++;
    if ({bus_b.out_valid, bus_b.in_ready, bus_b.out_ovf, bus_b.out_data} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_b: got v=%b r=%b o=%b d=%0d want v=0 r=1 o=0 d=0",
               bus_b.out_valid, bus_b.in_ready, bus_b.out_ovf, bus_b.out_data);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] p [4];
    p[0] = 16'd15; p[1] = 16'd65025; p[2] = 16'd0; p[3] = 16'd1;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = p[i];
      tick();
    end
    bus_a.in_valid = 1'b0;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data} !== {1'b1, 1'b0, 1'b0, 20'd65041}) begin
      n_bad++;
      $display("FAIL directed_result: got v=%b r=%b o=%b d=%0d want v=1 r=0 o=0 d=65041",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data);
    end
    tick();
    n_cmp++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_data} !== {1'b0, 1'b1, 20'd65041}) begin
      n_bad++;
      $display("FAIL directed_drain: got v=%b r=%b d=%0d want v=0 r=1 d=65041",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
    end
  endtask

  task automatic test_backpressure();
    longint total;
    total = 0;
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = rnd_prod();
      total += longint'(bus_a.product);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = rnd_prod();
      tick();
      n_cmp++;
      if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_data} !== {1'b1, 1'b0, WA'(total)}) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d]: got v=%b r=%b d=%0d want v=1 r=0 d=%0d",
                 i, bus_a.out_valid, bus_a.in_ready, bus_a.out_data, total);
      end
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus_a.out_valid, bus_a.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL backpressure_release: got v=%b r=%b want v=0 r=1",
               bus_a.out_valid, bus_a.in_ready);
    end
    total = 0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = rnd_prod();
      total += longint'(bus_a.product);
      tick();
    end
    bus_a.in_valid = 1'b0;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.out_ovf, bus_a.out_data} !== {1'b1, 1'b0, WA'(total)}) begin
      n_bad++;
      $display("FAIL backpressure_next: got v=%b o=%b d=%0d want v=1 o=0 d=%0d",
               bus_a.out_valid, bus_a.out_ovf, bus_a.out_data, total);
    end
    tick();
  endtask

  task automatic test_overflow();
    longint total;
    logic [15:0] want;
`ifdef DADDA_ACC_SAT_EN
    want = 16'd65535;
`else
    want = 16'd63492;
`endif
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.product  = 16'd65025;
      tick();
    end
    bus_b.in_valid = 1'b0;
    n_cmp++;
    if ({bus_b.out_valid, bus_b.out_ovf, bus_b.out_data} !== {1'b1, 1'b1, want}) begin
      n_bad++;
      $display("FAIL overflow_fixed: got v=%b o=%b d=%0d want v=1 o=1 d=%0d",
               bus_b.out_valid, bus_b.out_ovf, bus_b.out_data, want);
    end
    tick();
    for (int v = 0; v < 6; v++) begin
      total = 0;
      for (int i = 0; i < 4; i++) begin
        bus_b.in_valid = 1'b1;
        bus_b.product  = (v % 2 == 0) ? 16'($urandom_range(30000, 65025)) : rnd_prod();
        total += longint'(bus_b.product);
        tick();
      end
      bus_b.in_valid = 1'b0;
      n_cmp++;
      if ({bus_b.out_valid, bus_b.out_ovf, bus_b.out_data} !==
          {1'b1, (total >= 65536), WB'(exp_sum(total, WB))}) begin
        n_bad++;
        $display("FAIL overflow_rand[%0d]: got o=%b d=%0d want o=%b d=%0d (true sum %0d)",
                 v, bus_b.out_ovf, bus_b.out_data, (total >= 65536), exp_sum(total, WB), total);
      end
      tick();
    end
  endtask

  task automatic test_clear();
    logic [WA-1:0] prev;
    logic [WA-1:0] held;
    prev = bus_a.out_data;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = rnd_prod();
      tick();
    end
    clr_a = 1'b1;
    bus_a.product = 16'd99;
    tick();
    clr_a = 1'b0;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_data} !== {1'b0, 1'b1, prev}) begin
      n_bad++;
      $display("FAIL clear_idle: got v=%b r=%b d=%0d want v=0 r=1 d=%0d",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data, prev);
    end
    for (int i = 1; i <= 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = 16'(i);
      tick();
    end
    bus_a.in_valid = 1'b0;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.out_ovf, bus_a.out_data} !== {1'b1, 1'b0, 20'd10}) begin
      n_bad++;
      $display("FAIL clear_then_1234: got v=%b o=%b d=%0d want v=1 o=0 d=10",
               bus_a.out_valid, bus_a.out_ovf, bus_a.out_data);
    end
    tick();
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = 16'(100 + i);
      tick();
    end
    held = 20'd406;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data} !== {1'b0, 1'b1, 1'b0, held}) begin
      n_bad++;
      $display("FAIL clear_in_hold: got v=%b r=%b o=%b d=%0d want v=0 r=1 o=0 d=%0d",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data, held);
    end
  endtask

  task automatic test_reset_hold();
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = rnd_prod();
      tick();
    end
    bus_a.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_data} !== {1'b0, 1'b1, 20'd0}) begin
      n_bad++;
      $display("FAIL reset_in_hold: got v=%b r=%b d=%0d want v=0 r=1 d=0",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.product  = 16'd7;
      tick();
    end
    bus_a.in_valid = 1'b0;
    n_cmp++;
    if ({bus_a.out_valid, bus_a.out_ovf, bus_a.out_data} !== {1'b1, 1'b0, 20'd28}) begin
      n_bad++;
      $display("FAIL reset_then_7777: got v=%b o=%b d=%0d want v=1 o=0 d=28",
               bus_a.out_valid, bus_a.out_ovf, bus_a.out_data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus_a.in_valid  = ($urandom % 4) != 0;
      bus_a.product   = rnd_prod();
      bus_a.out_ready = ($urandom % 3) != 0;
      clr_a           = ($urandom % 40) == 0;
      tick();
      n_cmp++;
      if ({bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data} !==
          {m_hold, !m_hold, m_ovf, WA'(m_data)}) begin
        n_bad++;
        $display("FAIL random[%0d]: got v=%b r=%b o=%b d=%0d want v=%b r=%b o=%b d=%0d",
                 c, bus_a.out_valid, bus_a.in_ready, bus_a.out_ovf, bus_a.out_data,
                 m_hold, !m_hold, m_ovf, m_data);
      end
    end
    clr_a = 1'b0;
    bus_a.in_valid = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    clr_a           = 1'b0;
    clr_b           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.product   = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.product   = '0;
    bus_b.out_ready = 1'b1;
    model_reset();

    test_reset();
    test_directed();
    test_backpressure();
    test_overflow();
    test_clear();
    test_reset_hold();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
